// File: rtl/execute_branch_resolve_pkg.sv
// Branch-condition encodings and default squash depth shared by the execute-stage resolver.
package rv_branch_pkg;
   localparam logic [2:0] BR_EQ  = 3'b000;
   localparam logic [2:0] BR_NE  = 3'b001;
   localparam logic [2:0] BR_LT  = 3'b100;
   localparam logic [2:0] BR_GE  = 3'b101;
   localparam logic [2:0] BR_LTU = 3'b110;
   localparam logic [2:0] BR_GEU = 3'b111;

   localparam int SQUASH_SLOTS_DEF = 2;
endpackage

// File: rtl/execute_branch_resolve_if.sv
// Decode-to-execute control-flow bundle plus the fetch redirect and statistics returned by E.
// Inputs (_d, hold_e) are plain levels sampled at the capture edge; no valid/ready handshake.
interface execute_branch_resolve_if #(parameter int CNT_W = 16);
   logic             valid_d;
   logic [31:0]      pc_d;
   logic [31:0]      pcplus4_d;
   logic [31:0]      rs1_d;
   logic [31:0]      rs2_d;
   logic [31:0]      imm_d;
   logic             branch_d;
   logic             jump_d;
   logic             jalr_d;
   logic [2:0]       funct3_d;
   logic             hold_e;
   logic             valid_e;
   logic             pcsrc_e;
   logic [31:0]      pc_target_e;
   logic [31:0]      link_e;
   logic             misalign_e;
   logic             squash_busy;
   logic [CNT_W-1:0] br_count;
   logic [CNT_W-1:0] taken_count;

   modport master (
      output valid_d, pc_d, pcplus4_d, rs1_d, rs2_d, imm_d,
             branch_d, jump_d, jalr_d, funct3_d, hold_e,
      input  valid_e, pcsrc_e, pc_target_e, link_e, misalign_e,
             squash_busy, br_count, taken_count
   );

   modport slave (
      input  valid_d, pc_d, pcplus4_d, rs1_d, rs2_d, imm_d,
             branch_d, jump_d, jalr_d, funct3_d, hold_e,
      output valid_e, pcsrc_e, pc_target_e, link_e, misalign_e,
             squash_busy, br_count, taken_count
   );
endinterface

// File: rtl/branch_cond_cmp.sv
// Combinational branch condition: equality, signed and unsigned less-than, selected by funct3.
module branch_cond_cmp
   import rv_branch_pkg::*;
(
   input  logic [31:0] i_rs1,
   input  logic [31:0] i_rs2,
   input  logic [2:0]  i_funct3,
   output logic        o_cond
);
   logic w_eq;
   logic w_lt;
   logic w_ltu;

   always_comb begin
      w_eq   = (i_rs1 == i_rs2);
      w_lt   = ($signed(i_rs1) < $signed(i_rs2));
      w_ltu  = (i_rs1 < i_rs2);
      o_cond = 1'b0;
      case (i_funct3)
         BR_EQ:   o_cond = w_eq;
         BR_NE:   o_cond = ~w_eq;
         BR_LT:   o_cond = w_lt;
         BR_GE:   o_cond = ~w_lt;
         BR_LTU:  o_cond = w_ltu;
         BR_GEU:  o_cond = ~w_ltu;
         default: o_cond = 1'b0;
      endcase
   end
endmodule

// File: rtl/execute_branch_resolve.sv
// Execute-stage branch/jump resolver: ID/EX control-flow register, redirect to fetch,
// self-squash of wrong-path captures, and saturating branch statistics.
module execute_branch_resolve
   import rv_branch_pkg::*;
#(
   parameter int SQUASH_SLOTS = SQUASH_SLOTS_DEF,
   parameter int CNT_W        = 16
) (
   input logic                   clk,
   input logic                   rst,
   execute_branch_resolve_if.slave bus
);
   localparam int SQ_W = $clog2(SQUASH_SLOTS + 1);

   logic             r_valid;
   logic [31:0]      r_pc;
   logic [31:0]      r_pcplus4;
   logic [31:0]      r_rs1;
   logic [31:0]      r_rs2;
   logic [31:0]      r_imm;
   logic             r_branch;
   logic             r_jump;
   logic             r_jalr;
   logic [2:0]       r_funct3;
   logic [SQ_W-1:0]  r_squash_cnt;
   logic             r_resolved;
   logic             r_first;
   logic [CNT_W-1:0] r_br_count;
   logic [CNT_W-1:0] r_taken_count;

   logic             w_cond;
   logic             w_is_jalr;
   logic [31:0]      w_sum;
   logic [31:0]      w_target;
   logic             w_taken;
   logic             w_misalign;
   logic             w_pcsrc;

   branch_cond_cmp u_cmp (
      .i_rs1    (r_rs1),
      .i_rs2    (r_rs2),
      .i_funct3 (r_funct3),
      .o_cond   (w_cond)
   );

   always_comb begin
      w_is_jalr  = r_jump & r_jalr;
      w_sum      = (w_is_jalr ? r_rs1 : r_pc) + r_imm;
      w_target   = w_is_jalr ? {w_sum[31:1], 1'b0} : w_sum;
      w_taken    = r_valid & (r_jump | (r_branch & w_cond));
      w_misalign = w_taken & w_target[1];
      // resolved blocks a second redirect from the same instruction while E is held
      w_pcsrc    = w_taken & ~w_misalign & ~r_resolved;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid       <= 1'b0;
         r_pc          <= '0;
         r_pcplus4     <= '0;
         r_rs1         <= '0;
         r_rs2         <= '0;
         r_imm         <= '0;
         r_branch      <= 1'b0;
         r_jump        <= 1'b0;
         r_jalr        <= 1'b0;
         r_funct3      <= '0;
         r_squash_cnt  <= '0;
         r_resolved    <= 1'b0;
         r_first       <= 1'b0;
         r_br_count    <= '0;
         r_taken_count <= '0;
      end else begin
         if (r_first & r_valid & (r_branch | r_jump) & ~(&r_br_count))
            r_br_count <= r_br_count + CNT_W'(1);
         if (r_first & w_pcsrc & ~(&r_taken_count))
            r_taken_count <= r_taken_count + CNT_W'(1);

         if (bus.hold_e) begin
            if (w_pcsrc)
               r_resolved <= 1'b1;
            r_first <= 1'b0;
         end else begin
            // a redirect issued during a hold squashes the release capture itself
            r_valid   <= bus.valid_d & (r_squash_cnt == '0) & ~r_resolved;
            r_pc      <= bus.pc_d;
            r_pcplus4 <= bus.pcplus4_d;
            r_rs1     <= bus.rs1_d;
            r_rs2     <= bus.rs2_d;
            r_imm     <= bus.imm_d;
            r_branch  <= bus.branch_d;
            r_jump    <= bus.jump_d;
            r_jalr    <= bus.jalr_d;
            r_funct3  <= bus.funct3_d;
            if (w_pcsrc)
               r_squash_cnt <= SQ_W'(SQUASH_SLOTS);
            else if (r_resolved)
               r_squash_cnt <= SQ_W'(SQUASH_SLOTS - 1);
            else if (r_squash_cnt != '0)
               r_squash_cnt <= r_squash_cnt - SQ_W'(1);
            r_resolved <= 1'b0;
            r_first    <= 1'b1;
         end
      end
   end

   assign bus.valid_e     = r_valid;
   assign bus.pcsrc_e     = w_pcsrc;
   assign bus.pc_target_e = w_target;
   assign bus.link_e      = r_pcplus4;
   assign bus.misalign_e  = w_misalign;
   assign bus.squash_busy = (r_squash_cnt != '0);
   assign bus.br_count    = r_br_count;
   assign bus.taken_count = r_taken_count;
endmodule

// File: tb/tb_execute_branch_resolve.sv
// Bench for execute_branch_resolve: directed scenarios with literal expectations, then random
// traffic compared every cycle against an instruction-level model (two counter widths).
module tb_execute_branch_resolve;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic chk_en = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;

   logic        valid_d, branch_d, jump_d, jalr_d, hold_e;
   logic [31:0] pc_d, p4_d, rs1_d, rs2_d, imm_d;
   logic [2:0]  funct3_d;

   always #5 clk = ~clk;

   execute_branch_resolve_if #(.CNT_W(16)) bus16 ();
   execute_branch_resolve_if #(.CNT_W(2))  bus2 ();

   execute_branch_resolve #(.SQUASH_SLOTS(2), .CNT_W(16)) dut (
      .clk (clk), .rst (rst), .bus (bus16.slave));
   execute_branch_resolve #(.SQUASH_SLOTS(2), .CNT_W(2)) dut2 (
      .clk (clk), .rst (rst), .bus (bus2.slave));

   assign bus16.valid_d = valid_d;   assign bus2.valid_d = valid_d;
   assign bus16.pc_d = pc_d;         assign bus2.pc_d = pc_d;
   assign bus16.pcplus4_d = p4_d;    assign bus2.pcplus4_d = p4_d;
   assign bus16.rs1_d = rs1_d;       assign bus2.rs1_d = rs1_d;
   assign bus16.rs2_d = rs2_d;       assign bus2.rs2_d = rs2_d;
   assign bus16.imm_d = imm_d;       assign bus2.imm_d = imm_d;
   assign bus16.branch_d = branch_d; assign bus2.branch_d = branch_d;
   assign bus16.jump_d = jump_d;     assign bus2.jump_d = jump_d;
   assign bus16.jalr_d = jalr_d;     assign bus2.jalr_d = jalr_d;
   assign bus16.funct3_d = funct3_d; assign bus2.funct3_d = funct3_d;
   assign bus16.hold_e = hold_e;     assign bus2.hold_e = hold_e;

   // ---------------- reference model: the instruction currently in E ----------------
   logic        m_valid, m_br, m_jmp, m_jalr, m_res, m_first;
   logic [31:0] m_pc, m_p4, m_rs1, m_rs2, m_imm;
   logic [2:0]  m_f3;
   int          m_sq, m_brc, m_tkc, m_brc2, m_tkc2;

   function automatic logic f_cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] f_target();
      if (m_jmp && m_jalr) return (m_rs1 + m_imm) & 32'hFFFF_FFFE;
      return m_pc + m_imm;
   endfunction

   function automatic logic f_taken();
      return m_valid && (m_jmp || (m_br && f_cond(m_f3, m_rs1, m_rs2)));
   endfunction

   function automatic logic f_mis();
      logic [31:0] t;
      t = f_target();
      return f_taken() && t[1];
   endfunction

   function automatic logic f_pcsrc();
      return f_taken() && !f_mis() && !m_res;
   endfunction

   function automatic int f_sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   always @(posedge clk) begin : model
      logic fire;
      if (rst) begin
         m_valid = 0; m_br = 0; m_jmp = 0; m_jalr = 0; m_res = 0; m_first = 0;
         m_pc = 0; m_p4 = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_f3 = 0;
         m_sq = 0; m_brc = 0; m_tkc = 0; m_brc2 = 0; m_tkc2 = 0;
      end else begin
         fire = f_pcsrc();
         if (m_first && m_valid && (m_br || m_jmp)) begin
            m_brc  = f_sat(m_brc + 1, 65535);
            m_brc2 = f_sat(m_brc2 + 1, 3);
         end
         if (m_first && fire) begin
            m_tkc  = f_sat(m_tkc + 1, 65535);
            m_tkc2 = f_sat(m_tkc2 + 1, 3);
         end
         if (hold_e) begin
            if (fire) m_res = 1;
            m_first = 0;
         end else begin
            m_valid = valid_d && (m_sq == 0) && !m_res;
            if (fire) m_sq = 2;
            else if (m_res) m_sq = 1;
            else if (m_sq > 0) m_sq = m_sq - 1;
            m_res = 0; m_first = 1;
            m_pc = pc_d; m_p4 = p4_d; m_rs1 = rs1_d; m_rs2 = rs2_d; m_imm = imm_d;
            m_br = branch_d; m_jmp = jump_d; m_jalr = jalr_d; m_f3 = funct3_d;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      else n_pass++;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_valid_e", 32'(bus16.valid_e), 32'(m_valid));
         check("cmp_pcsrc_e", 32'(bus16.pcsrc_e), 32'(f_pcsrc()));
         check("cmp_pc_target_e", bus16.pc_target_e, f_target());
         check("cmp_link_e", bus16.link_e, m_p4);
         check("cmp_misalign_e", 32'(bus16.misalign_e), 32'(f_mis()));
         check("cmp_squash_busy", 32'(bus16.squash_busy), 32'(m_sq != 0));
         check("cmp_br_count", 32'(bus16.br_count), 32'(m_brc));
         check("cmp_taken_count", 32'(bus16.taken_count), 32'(m_tkc));
         check("cmp_br_count_w2", 32'(bus2.br_count), 32'(m_brc2));
         check("cmp_taken_count_w2", 32'(bus2.taken_count), 32'(m_tkc2));
         check("cmp_pcsrc_e_w2", 32'(bus2.pcsrc_e), 32'(f_pcsrc()));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      valid_d = 0; branch_d = 0; jump_d = 0; jalr_d = 0; funct3_d = 0; hold_e = 0;
      pc_d = 0; p4_d = 0; rs1_d = 0; rs2_d = 0; imm_d = 0;
   endtask

   task automatic set_instr(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] imm, input logic br, input logic jmp,
                            input logic jr, input logic [2:0] f3);
      valid_d = 1; pc_d = pc; p4_d = pc + 32'd4; rs1_d = a; rs2_d = b; imm_d = imm;
      branch_d = br; jump_d = jmp; jalr_d = jr; funct3_d = f3;
   endtask

   task automatic set_nop(input logic [31:0] pc);
      set_instr(pc, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // 1: reset with garbage, then idle
      valid_d = 1; branch_d = 1; jump_d = 1; jalr_d = 1; funct3_d = 3'($urandom); hold_e = 1;
      pc_d = $urandom; p4_d = $urandom; rs1_d = $urandom; rs2_d = $urandom; imm_d = $urandom;
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      set_idle();
      chk_en = 1;
      @(negedge clk);
      check("rst_valid_e", 32'(bus16.valid_e), 32'd0);
      check("rst_pcsrc_e", 32'(bus16.pcsrc_e), 32'd0);
      check("rst_pc_target_e", bus16.pc_target_e, 32'd0);
      check("rst_link_e", bus16.link_e, 32'd0);
      check("rst_misalign_e", 32'(bus16.misalign_e), 32'd0);
      check("rst_squash_busy", 32'(bus16.squash_busy), 32'd0);
      check("rst_taken_count", 32'(bus16.taken_count), 32'd0);
      tick();
      @(negedge clk);
      check("idle_br_count", 32'(bus16.br_count), 32'd0);

      // 2: taken beq and its two squashed follow-on captures
      set_instr(32'h100, 32'd5, 32'd5, 32'h20, 1, 0, 0, 3'd0);
      tick();
      set_nop(32'h104);
      @(negedge clk);
      check("beq_pcsrc_e", 32'(bus16.pcsrc_e), 32'd1);
      check("beq_target", bus16.pc_target_e, 32'h120);
      check("model_beq_target", f_target(), 32'h120);
      tick();
      @(negedge clk);
      check("beq_squash_busy", 32'(bus16.squash_busy), 32'd1);
      tick();
      @(negedge clk);
      check("beq_squash1_valid", 32'(bus16.valid_e), 32'd0);
      tick();
      @(negedge clk);
      check("beq_squash2_valid", 32'(bus16.valid_e), 32'd0);
      tick();
      @(negedge clk);
      check("beq_after_squash_valid", 32'(bus16.valid_e), 32'd1);
      check("beq_after_squash_busy", 32'(bus16.squash_busy), 32'd0);

      // 3: signed vs unsigned less-than on the same operands
      set_instr(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1, 0, 0, 3'd4);
      tick();
      set_idle();
      @(negedge clk);
      check("blt_pcsrc_e", 32'(bus16.pcsrc_e), 32'd1);
      check("blt_target", bus16.pc_target_e, 32'h240);
      repeat (3) tick();
      set_instr(32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, 1, 0, 0, 3'd6);
      tick();
      set_idle();
      @(negedge clk);
      check("bltu_pcsrc_e", 32'(bus16.pcsrc_e), 32'd0);
      check("bltu_valid_e", 32'(bus16.valid_e), 32'd1);
      tick();
      @(negedge clk);
      check("bltu_br_count", 32'(bus16.br_count), 32'd3);
      check("bltu_taken_count", 32'(bus16.taken_count), 32'd2);

      // 4: misaligned jalr (no redirect, no squash), then aligned jalr
      set_instr(32'h400, 32'h1003, 32'd0, 32'h4, 0, 1, 1, 3'd0);
      tick();
      set_idle();
      @(negedge clk);
      check("jalr_mis_target", bus16.pc_target_e, 32'h1006);
      check("jalr_mis_misalign", 32'(bus16.misalign_e), 32'd1);
      check("jalr_mis_pcsrc", 32'(bus16.pcsrc_e), 32'd0);
      check("jalr_mis_link", bus16.link_e, 32'h404);
      tick();
      @(negedge clk);
      check("jalr_mis_no_squash", 32'(bus16.squash_busy), 32'd0);
      set_instr(32'h500, 32'h1001, 32'd0, 32'h4, 0, 1, 1, 3'd0);
      tick();
      set_idle();
      @(negedge clk);
      check("jalr_target", bus16.pc_target_e, 32'h1004);
      check("jalr_pcsrc", 32'(bus16.pcsrc_e), 32'd1);
      repeat (3) tick();

      // 5: taken beq held for three cycles
      set_instr(32'h600, 32'd7, 32'd7, 32'h10, 1, 0, 0, 3'd0);
      tick();
      set_nop(32'h604);
      hold_e = 1;
      @(negedge clk);
      check("hold_c1_pcsrc", 32'(bus16.pcsrc_e), 32'd1);
      tick();
      @(negedge clk);
      check("hold_c2_pcsrc", 32'(bus16.pcsrc_e), 32'd0);
      check("hold_c2_valid", 32'(bus16.valid_e), 32'd1);
      tick();
      @(negedge clk);
      check("hold_c3_pcsrc", 32'(bus16.pcsrc_e), 32'd0);
      tick();
      hold_e = 0;
      @(negedge clk);
      check("hold_rel_pcsrc", 32'(bus16.pcsrc_e), 32'd0);
      tick();
      @(negedge clk);
      check("hold_rel_capture_valid", 32'(bus16.valid_e), 32'd0);
      check("hold_rel_squash_busy", 32'(bus16.squash_busy), 32'd1);
      check("hold_taken_count", 32'(bus16.taken_count), 32'd4);
      check("hold_br_count", 32'(bus16.br_count), 32'd6);
      tick();
      @(negedge clk);
      check("hold_squash2_valid", 32'(bus16.valid_e), 32'd0);
      tick();
      @(negedge clk);
      check("hold_after_valid", 32'(bus16.valid_e), 32'd1);

      // 6: reset right after a redirect abandons the squash
      set_instr(32'h700, 32'd1, 32'd1, 32'h8, 1, 0, 0, 3'd0);
      tick();
      set_nop(32'h704);
      @(negedge clk);
      check("rstsq_pcsrc", 32'(bus16.pcsrc_e), 32'd1);
      tick();
      rst = 1;
      tick();
      rst = 0;
      @(negedge clk);
      check("rstsq_busy", 32'(bus16.squash_busy), 32'd0);
      check("rstsq_taken_count", 32'(bus16.taken_count), 32'd0);
      tick();
      @(negedge clk);
      check("rstsq_accept_valid", 32'(bus16.valid_e), 32'd1);

      // saturation of the 2-bit counters with five taken branches
      for (int i = 0; i < 5; i++) begin
         set_instr(32'h800 + 32'(i * 16), 32'd3, 32'd3, 32'h40, 1, 0, 0, 3'd0);
         tick();
         set_idle();
         repeat (3) tick();
      end
      @(negedge clk);
      check("sat_taken_w16", 32'(bus16.taken_count), 32'd5);
      check("sat_taken_w2", 32'(bus2.taken_count), 32'd3);
      check("sat_br_w2", 32'(bus2.br_count), 32'd3);

      // random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         rst      = ($urandom_range(0, 299) == 0);
         hold_e   = ($urandom_range(0, 3) == 0);
         valid_d  = ($urandom_range(0, 4) != 0);
         branch_d = $urandom_range(0, 1) == 1;
         jump_d   = !branch_d && ($urandom_range(0, 2) == 0);
         jalr_d   = $urandom_range(0, 1) == 1;
         funct3_d = 3'($urandom_range(0, 7));
         pc_d     = $urandom & 32'hFFFF_FFFC;
         p4_d     = pc_d + 32'd4;
         rs1_d    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         rs2_d    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         imm_d    = 32'($urandom_range(0, 127)) - 32'd64;
         tick();
      end
      rst = 0;
      set_idle();
      repeat (2) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
